// File: rtl/sqrt_arbiter_pkg.sv
// Shared types and constants for the sqrt_arbiter block.
package sqrt_arbiter_pkg;

  localparam int X_W         = 8;   // radicand width
  localparam int Y_W         = 4;   // floor-sqrt result width
  localparam int DEF_TIMEOUT = 32;  // default WAIT cycles before timeout

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_arbiter_rr.sv
// Round-robin picker: first requester after last_grant, wrapping around.
module sqrt_arbiter_rr #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Scan offsets 1..NUM_REQ from last_grant; last_grant itself is lowest priority.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!any_grant && req[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared square-root unit, one
// transaction in flight at a time. Optional WAIT timeout is compiled in
// with SQRT_ARBITER_TIMEOUT_EN.
module sqrt_arbiter
  import sqrt_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*X_W-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [Y_W-1:0]         rsp_data,
  output logic                   rsp_err,
  output logic [X_W-1:0]         sq_x_in,
  output logic                   sq_x_ready,
  input  logic [Y_W-1:0]         sq_y_out,
  input  logic                   sq_y_ready,
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   g;
  logic [Y_W-1:0]     result;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;

  sqrt_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

`ifdef SQRT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_flag;
`else
  assign rsp_err = 1'b0;
`endif

  // Main FSM; every output is registered and pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      g          <= '0;
      result     <= '0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      sq_x_in    <= '0;
      sq_x_ready <= 1'b0;
      busy       <= 1'b0;
`ifdef SQRT_ARBITER_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_flag   <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      req_ack    <= '0;
      rsp_valid  <= '0;
      sq_x_ready <= 1'b0;
`ifdef SQRT_ARBITER_TIMEOUT_EN
      rsp_err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (any_grant) begin
            req_ack <= grant;
            g       <= grant_idx;
            sq_x_in <= req_data[grant_idx*X_W +: X_W];
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          sq_x_ready <= 1'b1;
          state      <= S_WAIT;
`ifdef SQRT_ARBITER_TIMEOUT_EN
          tmo_cnt    <= '0;
          err_flag   <= 1'b0;
`endif
        end
        S_WAIT: begin
          if (sq_y_ready) begin
            result <= sq_y_out;
            state  <= S_RESP;
          end
`ifdef SQRT_ARBITER_TIMEOUT_EN
          // Last WAIT cycle without an answer: respond with an error and zero.
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            result   <= '0;
            err_flag <= 1'b1;
            state    <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          rsp_valid[g] <= 1'b1;
          rsp_data     <= result;
          last_grant   <= g;
          busy         <= 1'b0;
          state        <= S_IDLE;
`ifdef SQRT_ARBITER_TIMEOUT_EN
          rsp_err      <= err_flag;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-002 Parameter NUM_REQ, default 2, SHALL be the number of requesters (2..8).
REQ-003 Parameter TIMEOUT_CYCLES, default 32, SHALL be the maximum number of WAIT cycles before timeout (used only with the macro).
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  NUM_REQ  per-requester request, held until acked
- req_data  in  NUM_REQ*8  radicand; requester i uses bits [8i+7:8i]
- req_ack  out  NUM_REQ  one-hot 1-cycle accept pulse
- rsp_valid  out  NUM_REQ  one-hot 1-cycle result pulse
- rsp_data  out  4  floor square root, valid while any rsp_valid bit is high
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- sq_x_in  out  8  radicand to the shared sqrt unit
- sq_x_ready  out  1  1-cycle start pulse to the sqrt unit
- sq_y_out  in  4  sqrt unit result
- sq_y_ready  in  1  sqrt unit 1-cycle done pulse
- busy  out  1  high in every state except IDLE

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; exactly one request SHALL be in flight at a time.
REQ-006 In IDLE with any req_valid high, the FSM SHALL grant one requester by round-robin, starting at the requester after last_grant.
- The same cycle, it SHALL pulse req_ack[g] and latch req_data[g] and g.
- Next state: ISSUE.
REQ-007 In ISSUE, the block SHALL drive sq_x_ready=1 for exactly one cycle, with sq_x_in equal to the latched radicand; next state: WAIT.
REQ-008 In WAIT, on sq_y_ready=1, the block SHALL latch sq_y_out; next state: RESP.
REQ-009 In RESP, the block SHALL pulse rsp_valid[g] for one cycle with rsp_data equal to the latched result.
- It SHALL update last_grant to g.
- Next state: IDLE.
REQ-010 Latency SHALL be:
- rsp_valid exactly 2 cycles after the sq_y_ready pulse;
- sq_x_ready exactly 1 cycle after req_ack.
REQ-011 sq_y_ready SHALL be ignored outside WAIT.
REQ-012 req_valid changes outside IDLE SHALL be ignored; a request withdrawn before ack SHALL never be served.
REQ-013 With no requests, the block SHALL remain in IDLE with all pulse outputs low.
REQ-014 sq_x_in SHALL hold the last latched radicand between issues.
- rsp_data SHALL hold the last result.

Reset
REQ-015 While rst_n is low, the block SHALL hold the FSM in IDLE and all outputs at 0.
- last_grant SHALL reset to NUM_REQ-1, so requester 0 has first priority.
- The timeout counter SHALL reset to 0.
REQ-016 Reset asserted mid-operation (ISSUE, WAIT or RESP) SHALL abort the request with no rsp_valid; a late sq_y_ready after reset SHALL be ignored.

Configuration
REQ-017 With SQRT_ARBITER_TIMEOUT_EN defined, WAIT SHALL count cycles.
- If sq_y_ready has not arrived after TIMEOUT_CYCLES cycles, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0.
- The counter SHALL clear on entry to WAIT.
REQ-018 Without SQRT_ARBITER_TIMEOUT_EN, WAIT SHALL last indefinitely, rsp_err SHALL be tied to 0, and no counter SHALL be synthesized.

Structure
REQ-019 Package sqrt_arbiter_pkg SHALL hold:
- the FSM state enum typedef;
- radicand width (8) and result width (4) constants;
- the default TIMEOUT_CYCLES.
REQ-020 Round-robin selection SHALL be a sub-module, sqrt_arbiter_rr.
- Inputs: request vector, last_grant.
- Outputs: one-hot grant, grant index, any_grant.

Verification
REQ-021 Single request: req 0, x=203 -> req_ack[0] then sq_x_ready with sq_x_in=203; model returns 14 -> rsp_valid[0], rsp_data=14.
REQ-022 Simultaneous requests after reset: req0 x=144, req1 x=255 -> req0 served first (rsp 12), then req1 (rsp 15).
REQ-023 Fairness: both req_valid held high with re-presented data for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-024 Reset in WAIT: drop rst_n while waiting, then model pulses sq_y_ready -> no rsp_valid, FSM in IDLE, busy=0.
REQ-025 Spurious sq_y_ready in IDLE -> no rsp_valid, no state change.
REQ-026 Timeout (macro defined, TIMEOUT_CYCLES=32): model never answers -> rsp_valid[g] with rsp_err=1, rsp_data=0 exactly 33 cycles after the WAIT state is entered; next request is served normally.
